// File: rtl/imm_instr_encoder.sv
// RV32I immediate encoder: packs fields plus a signed immediate into I/S/B/J words,
// range/alignment-checks each request and queues good words with sequential byte addresses.
module imm_instr_encoder #(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_enc_valid,
   output logic             o_enc_ready,
   input  logic [1:0]       i_enc_ImmSrc,
   input  logic [6:0]       i_enc_op,
   input  logic [4:0]       i_enc_rd,
   input  logic [2:0]       i_enc_funct3,
   input  logic [4:0]       i_enc_rs1,
   input  logic [4:0]       i_enc_rs2,
   input  logic [31:0]      i_enc_imm,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [31:0]      o_out_instr,
   output logic [31:0]      o_out_addr,
   output logic             o_err,
   output logic [1:0]       o_err_code,
   output logic [CNT_W-1:0] o_err_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } entry_t;

   entry_t            mem [FIFO_DEPTH];
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic [31:0]       next_addr;

   fmt_e              fmt;
   logic [31:0]       instr;
   logic signed [31:0] imm_s;
   logic              range_bad, align_bad;
   logic              accept, push, pop, reject;

   // Field packing is the exact inverse of the datapath immediate extender.
   always_comb begin
      fmt        = fmt_e'(i_enc_ImmSrc);
      imm_s      = $signed(i_enc_imm);
      instr      = '0;
      instr[6:0] = i_enc_op;
      range_bad  = 1'b0;
      align_bad  = 1'b0;
      case (fmt)
         FMT_I: begin
            instr[11:7]  = i_enc_rd;
            instr[14:12] = i_enc_funct3;
            instr[19:15] = i_enc_rs1;
            instr[31:20] = i_enc_imm[11:0];
            range_bad    = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_S: begin
            instr[11:7]  = i_enc_imm[4:0];
            instr[14:12] = i_enc_funct3;
            instr[19:15] = i_enc_rs1;
            instr[24:20] = i_enc_rs2;
            instr[31:25] = i_enc_imm[11:5];
            range_bad    = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_B: begin
            instr[7]     = i_enc_imm[11];
            instr[11:8]  = i_enc_imm[4:1];
            instr[14:12] = i_enc_funct3;
            instr[19:15] = i_enc_rs1;
            instr[24:20] = i_enc_rs2;
            instr[30:25] = i_enc_imm[10:5];
            instr[31]    = i_enc_imm[12];
            range_bad    = (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
            align_bad    = i_enc_imm[0];
         end
         FMT_J: begin
            instr[11:7]  = i_enc_rd;
            instr[19:12] = i_enc_imm[19:12];
            instr[20]    = i_enc_imm[11];
            instr[30:21] = i_enc_imm[10:1];
            instr[31]    = i_enc_imm[20];
            range_bad    = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
            align_bad    = i_enc_imm[0];
         end
      endcase
   end

   assign o_enc_ready = (count != FULL_CNT);
   assign o_out_valid = (count != '0);
   assign accept      = i_enc_valid && o_enc_ready;
   assign reject      = accept && (range_bad || align_bad);
   assign push        = accept && !(range_bad || align_bad);
   assign pop         = o_out_valid && i_out_ready;

   assign head        = mem[rd_ptr];
   assign o_out_instr = o_out_valid ? head.instr : '0;
   assign o_out_addr  = o_out_valid ? head.addr  : '0;

   // NOTE: FIFO storage has no reset; entries are only observable through the occupancy
   // count, so the outputs are masked to zero while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (push && !i_clr) mem[wr_ptr] <= '{instr: instr, addr: next_addr};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         next_addr  <= BASE_ADDR;
         o_err      <= 1'b0;
         o_err_code <= 2'b00;
         o_err_cnt  <= '0;
      end else if (i_clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         next_addr  <= BASE_ADDR;
         o_err      <= 1'b0;
         o_err_code <= 2'b00;
         o_err_cnt  <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            next_addr <= next_addr + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         case ({push, pop})
            2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
            default: count <= count;
         endcase
         o_err <= reject;
         if (reject) begin
            o_err_code <= {align_bad, range_bad};
            if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: stimulus queues expected words/errors,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_imm_instr_encoder;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;
   localparam logic [1:0]  I = 2'b00, S = 2'b01, B = 2'b10, J = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n, clr, enc_valid, enc_ready, out_valid, out_ready, err;
   logic [1:0]  imm_src, err_code;
   logic [6:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm, out_instr, out_addr;
   logic [7:0]  err_cnt;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   exp_t        exp_q[$];
   logic [1:0]  err_q[$];
   logic [31:0] exp_addr = BASE;
   int          exp_err_cnt = 0;
   int          tests = 0;
   int          fails = 0;

   imm_instr_encoder #(.FIFO_DEPTH(2), .BASE_ADDR(BASE), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_enc_valid(enc_valid), .o_enc_ready(enc_ready), .i_enc_ImmSrc(imm_src),
      .i_enc_op(op), .i_enc_rd(rd), .i_enc_funct3(f3), .i_enc_rs1(rs1),
      .i_enc_rs2(rs2), .i_enc_imm(imm),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_instr(out_instr), .o_out_addr(out_addr),
      .o_err(err), .o_err_code(err_code), .o_err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Issue one request; on acceptance queue the expected word or error code.
   task automatic send(input logic [1:0] fmt, input logic [6:0] o, input logic [4:0] d,
                       input logic [2:0] f, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, input logic [31:0] exp_instr,
                       input logic [1:0] exp_err);
      int n = 0;
      imm_src = fmt; op = o; rd = d; f3 = f; rs1 = s1; rs2 = s2; imm = im;
      enc_valid = 1'b1;
      while (!enc_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         fail_now("ready_wait");
         enc_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (exp_err == 2'b00) begin
         exp_q.push_back('{instr: exp_instr, addr: exp_addr});
         exp_addr = exp_addr + 32'd4;
      end else begin
         err_q.push_back(exp_err);
         if (exp_err_cnt != 255) exp_err_cnt++;
      end
      #1;
      enc_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) fail_now("drain");
   endtask

   always @(negedge clk) begin
      if (rst_n && !clr) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %h @ %h, expected none", out_instr, out_addr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_instr", out_instr, e.instr);
               check("out_addr", out_addr, e.addr);
            end
         end
         if (err) begin
            if (err_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_err: got code %b, expected no error", err_code);
            end else begin
               check("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; enc_valid = 1'b0; out_ready = 1'b1;
      imm_src = I; op = '0; rd = '0; f3 = '0; rs1 = '0; rs2 = '0; imm = '0;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("rst_enc_ready", {31'd0, enc_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // addi x1,x0,-1 at BASE; valid one cycle after accept
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      // sw x2,8(x3) and beq x0,x0,-4 back-to-back; second address wraps to 0
      send(S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'd8, 32'h0021_A423, 2'b00);
      send(B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'b00);
      drain();

      // J good, then out of range
      send(J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 2'b00);
      send(J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd1048576, 32'h0, 2'b01);
      drain();
      check("err_cnt_j", {24'd0, err_cnt}, exp_err_cnt);

      // B misaligned, B both, then good B keeps the unchanged address
      send(B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, 32'h0, 2'b10);
      send(B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd4095, 32'h0, 2'b11);
      send(B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 2'b00);
      drain();
      check("err_cnt_b", {24'd0, err_cnt}, exp_err_cnt);
      check("err_code_held", {30'd0, err_code}, 32'd3);

      // Range boundaries
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0093, 2'b00);
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 32'h0, 2'b01);
      send(S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'hFFFF_F800, 32'h8021_A023, 2'b00);
      send(J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_00EF, 2'b00);
      send(J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd1048574, 32'h7FFF_F0EF, 2'b00);
      send(J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd1, 32'h0, 2'b10);
      drain();

      // Backpressure: fill DEPTH 2, third waits, head stable, then order preserved
      out_ready = 1'b0;
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00);
      send(S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'd8, 32'h0021_A423, 2'b00);
      check("full_ready_low", {31'd0, enc_ready}, 32'd0);
      fork
         send(B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'b00);
         begin
            repeat (3) begin
               @(negedge clk);
               check("head_stable", out_instr, 32'hFFF0_0093);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Saturating error counter
      for (int k = 0; k < 260; k++)
         send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd4096, 32'h0, 2'b01);
      drain();
      check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

      // Synchronous clear with two entries queued
      out_ready = 1'b0;
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'b00);
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd6, 32'h0060_0093, 2'b00);
      clr = 1'b1;
      exp_q.delete();
      exp_addr = BASE;
      exp_err_cnt = 0;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);
      check("clr_out_instr", out_instr, 32'd0);
      check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("clr_err_code", {30'd0, err_code}, 32'd0);
      out_ready = 1'b1;
      send(I, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 32'd1, 32'h0010_0113, 2'b00);
      drain();

      // Asynchronous reset mid-stream with two entries queued
      send(B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'd5, 32'h0, 2'b10);
      out_ready = 1'b0;
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd7, 32'h0070_0093, 2'b00);
      send(I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd8, 32'h0080_0093, 2'b00);
      check("pre_rst_err_cnt", {24'd0, err_cnt}, exp_err_cnt);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      err_q.delete();
      exp_addr = BASE;
      exp_err_cnt = 0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(I, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 32'd2, 32'h0020_0193, 2'b00);
      drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
